// File: rtl/board_keeper.sv
// Tic-tac-toe board store with a sequential 8-line win/full scan after each committed move.
// Optional BOARD_WIN_LINE_EN adds the win_line output (index of the latched winning line).
module board_keeper #(
  parameter int SCAN_LINES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_e,
  input  logic [3:0]  pos,
  input  logic [1:0]  player,
  output logic [1:0]  state,
  output logic        win,
  output logic [1:0]  winner,
  output logic        full,
  output logic        scan_busy,
  output logic        scan_done,
  output logic        wr_drop,
  output logic [17:0] board
`ifdef BOARD_WIN_LINE_EN
  ,
  output logic [2:0]  win_line
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} fsm_e;

  localparam logic [2:0] LAST_LI = 3'(SCAN_LINES - 1);

  fsm_e       fsm_q;
  logic [1:0] cells_q [9];
  logic [2:0] li_q;
  logic       hit_q;
  logic [1:0] hit_player_q;
  logic       win_q;
  logic [1:0] winner_q;
  logic       full_q;
  logic       scan_busy_q;
  logic       scan_done_q;
  logic       wr_drop_q;
`ifdef BOARD_WIN_LINE_EN
  logic [2:0] hit_line_q;
  logic [2:0] win_line_q;
`endif

  logic       pos_ok;
  logic [1:0] rd_cell;
  logic       player_ok;
  logic       accept_d;
  logic [3:0] la, lb, lc;
  logic       line_hit;
  logic       all_occ;
  logic [17:0] board_flat;

  assign pos_ok    = (pos <= 4'd8);
  assign player_ok = (player == 2'b01) || (player == 2'b10);

  // Out-of-range positions read as occupied so the controller never targets them.
  always_comb begin
    rd_cell = 2'b11;
    if (pos_ok) rd_cell = cells_q[pos];
  end

  assign accept_d = w_e && pos_ok && (rd_cell == 2'b00) && player_ok &&
                    (fsm_q == IDLE) && !win_q;

  always_comb begin
    la = 4'd0; lb = 4'd1; lc = 4'd2;
    case (li_q)
      3'd0: begin la = 4'd0; lb = 4'd1; lc = 4'd2; end
      3'd1: begin la = 4'd3; lb = 4'd4; lc = 4'd5; end
      3'd2: begin la = 4'd6; lb = 4'd7; lc = 4'd8; end
      3'd3: begin la = 4'd0; lb = 4'd3; lc = 4'd6; end
      3'd4: begin la = 4'd1; lb = 4'd4; lc = 4'd7; end
      3'd5: begin la = 4'd2; lb = 4'd5; lc = 4'd8; end
      3'd6: begin la = 4'd0; lb = 4'd4; lc = 4'd8; end
      default: begin la = 4'd2; lb = 4'd4; lc = 4'd6; end
    endcase
  end

  assign line_hit = (cells_q[la] != 2'b00) && (cells_q[la] == cells_q[lb]) &&
                    (cells_q[lb] == cells_q[lc]);

  always_comb begin
    all_occ    = 1'b1;
    board_flat = '0;
    for (int i = 0; i < 9; i++) begin
      if (cells_q[i] == 2'b00) all_occ = 1'b0;
      board_flat[2*i +: 2] = cells_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= IDLE;
      for (int i = 0; i < 9; i++) cells_q[i] <= 2'b00;
      li_q         <= 3'd0;
      hit_q        <= 1'b0;
      hit_player_q <= 2'b00;
      win_q        <= 1'b0;
      winner_q     <= 2'b00;
      full_q       <= 1'b0;
      scan_busy_q  <= 1'b0;
      scan_done_q  <= 1'b0;
      wr_drop_q    <= 1'b0;
`ifdef BOARD_WIN_LINE_EN
      hit_line_q   <= 3'd0;
      win_line_q   <= 3'd0;
`endif
    end else begin
      scan_done_q <= 1'b0;
      wr_drop_q   <= w_e && !accept_d;
      case (fsm_q)
        IDLE: begin
          if (accept_d) begin
            cells_q[pos] <= player;
            fsm_q        <= SCAN;
            li_q         <= 3'd0;
            hit_q        <= 1'b0;
            hit_player_q <= 2'b00;
            scan_busy_q  <= 1'b1;
`ifdef BOARD_WIN_LINE_EN
            hit_line_q   <= 3'd0;
`endif
          end
        end
        SCAN: begin
          // Only the lowest-indexed matching line is kept.
          if (line_hit && !hit_q) begin
            hit_q        <= 1'b1;
            hit_player_q <= cells_q[la];
`ifdef BOARD_WIN_LINE_EN
            hit_line_q   <= li_q;
`endif
          end
          if (li_q == LAST_LI) begin
            fsm_q       <= DONE;
            scan_busy_q <= 1'b0;
          end else begin
            li_q <= li_q + 3'd1;
          end
        end
        DONE: begin
          if (hit_q) begin
            win_q    <= 1'b1;
            winner_q <= hit_player_q;
`ifdef BOARD_WIN_LINE_EN
            win_line_q <= hit_line_q;
`endif
          end
          full_q      <= all_occ;
          scan_done_q <= 1'b1;
          fsm_q       <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign state     = rd_cell;
  assign win       = win_q;
  assign winner    = winner_q;
  assign full      = full_q;
  assign scan_busy = scan_busy_q;
  assign scan_done = scan_done_q;
  assign wr_drop   = wr_drop_q;
  assign board     = board_flat;
`ifdef BOARD_WIN_LINE_EN
  assign win_line  = win_line_q;
`endif

endmodule

// File: tb/tb_board_keeper.sv
// Directed bench for board_keeper: table of writes with hand-computed outcomes plus
// hand-written reset/mid-scan sequences. Checks win_line when BOARD_WIN_LINE_EN is defined.
module tb_board_keeper;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_e;
  logic [3:0]  pos;
  logic [1:0]  player;
  logic [1:0]  state;
  logic        win;
  logic [1:0]  winner;
  logic        full;
  logic        scan_busy;
  logic        scan_done;
  logic        wr_drop;
  logic [17:0] board;
`ifdef BOARD_WIN_LINE_EN
  logic [2:0]  win_line;
`endif

  board_keeper dut (
    .clk       (clk),
    .rst       (rst),
    .w_e       (w_e),
    .pos       (pos),
    .player    (player),
    .state     (state),
    .win       (win),
    .winner    (winner),
    .full      (full),
    .scan_busy (scan_busy),
    .scan_done (scan_done),
    .wr_drop   (wr_drop),
    .board     (board)
`ifdef BOARD_WIN_LINE_EN
    ,
    .win_line  (win_line)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       do_rst;
    logic [3:0] pos;
    logic [1:0] player;
    logic       acc;
    logic       win;
    logic [1:0] winner;
    logic       full;
    logic [2:0] line;
  } vec_t;

  typedef struct {
    logic [3:0] pos;
    logic [1:0] exp;
  } rd_t;

  vec_t       vecs [18];
  rd_t        rds  [16];
  logic [1:0] model [9];
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] model_board();
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = model[i];
    return b;
  endfunction

  task automatic reset_dut();
    rst = 1'b1; w_e = 1'b0; pos = 4'd0; player = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) model[i] = 2'b00;
  endtask

  task automatic do_write(input logic [3:0] p, input logic [1:0] pl);
    w_e = 1'b1; pos = p; player = pl;
    tick();
    w_e = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    int busy_cnt;
    int lat;
    bit done_seen;
    if (v.do_rst) reset_dut();
    do_write(v.pos, v.player);
    if (v.acc) begin
      model[v.pos] = v.player;
      check($sformatf("v%0d wr_drop", idx), wr_drop, 0);
      check($sformatf("v%0d board", idx), board, model_board());
      check($sformatf("v%0d busy_start", idx), scan_busy, 1);
      busy_cnt = 1; lat = 0; done_seen = 0;
      for (int k = 0; k < 20 && !done_seen; k++) begin
        tick();
        lat++;
        if (scan_busy) busy_cnt++;
        if (scan_done) done_seen = 1;
      end
      check($sformatf("v%0d scan_done_seen", idx), done_seen, 1);
      check($sformatf("v%0d busy_cycles", idx), busy_cnt, 8);
      check($sformatf("v%0d latency", idx), lat, 9);
      tick();
      check($sformatf("v%0d done_pulse_end", idx), scan_done, 0);
    end else begin
      check($sformatf("v%0d wr_drop", idx), wr_drop, 1);
      check($sformatf("v%0d board_kept", idx), board, model_board());
      check($sformatf("v%0d no_busy", idx), scan_busy, 0);
      tick();
      check($sformatf("v%0d drop_pulse_end", idx), wr_drop, 0);
    end
    check($sformatf("v%0d win", idx), win, v.win);
    check($sformatf("v%0d winner", idx), winner, v.winner);
    check($sformatf("v%0d full", idx), full, v.full);
`ifdef BOARD_WIN_LINE_EN
    check($sformatf("v%0d win_line", idx), win_line, v.win ? v.line : 3'd0);
`endif
  endtask

  initial begin
    bit done_seen;

    // do_rst, pos, player, acc, win, winner, full, line
    vecs[0]  = '{1'b1, 4'd4,  2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0};
    vecs[1]  = '{1'b0, 4'd0,  2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0};
    vecs[2]  = '{1'b0, 4'd8,  2'b01, 1'b1, 1'b1, 2'b01, 1'b0, 3'd6};
    vecs[3]  = '{1'b0, 4'd1,  2'b10, 1'b0, 1'b1, 2'b01, 1'b0, 3'd6};
    vecs[4]  = '{1'b1, 4'd0,  2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0};
    vecs[5]  = '{1'b0, 4'd0,  2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0};
    vecs[6]  = '{1'b0, 4'd1,  2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0};
    vecs[7]  = '{1'b0, 4'd9,  2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0};
    vecs[8]  = '{1'b0, 4'd2,  2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0};
    vecs[9]  = '{1'b0, 4'd3,  2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0};
    vecs[10] = '{1'b0, 4'd3,  2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0};
    vecs[11] = '{1'b0, 4'd4,  2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0};
    vecs[12] = '{1'b0, 4'd4,  2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0};
    vecs[13] = '{1'b0, 4'd5,  2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0};
    vecs[14] = '{1'b0, 4'd6,  2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0};
    vecs[15] = '{1'b0, 4'd7,  2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0};
    vecs[16] = '{1'b0, 4'd15, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0};
    vecs[17] = '{1'b0, 4'd8,  2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 3'd0};

    for (int i = 0; i < 16; i++) begin
      rds[i].pos = 4'(i);
      rds[i].exp = (i <= 8) ? 2'b00 : 2'b11;
    end

    // Reset state and combinational reads across the whole pos range.
    reset_dut();
    check("rst board", board, 0);
    check("rst win", win, 0);
    check("rst winner", winner, 0);
    check("rst full", full, 0);
    check("rst busy", scan_busy, 0);
    check("rst done", scan_done, 0);
    check("rst drop", wr_drop, 0);
`ifdef BOARD_WIN_LINE_EN
    check("rst win_line", win_line, 0);
`endif
    for (int i = 0; i < 16; i++) begin
      pos = rds[i].pos;
      #1;
      check($sformatf("rd pos%0d", i), state, rds[i].exp);
    end

    for (int i = 0; i < 18; i++) apply_vec(vecs[i], i);
    check("full board value", board, 18'h16A59);
    pos = 4'd4; #1;
    check("rd full pos4", state, 2'b10);
    pos = 4'd7; #1;
    check("rd full pos7", state, 2'b01);

    // Row 0 completed, a mid-scan write dropped, then reset aborts the scan.
    reset_dut();
    apply_vec('{1'b0, 4'd0, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0}, 100);
    apply_vec('{1'b0, 4'd1, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0}, 101);
    do_write(4'd2, 2'b01);
    check("abort board", board, 18'h00015);
    check("abort busy", scan_busy, 1);
    do_write(4'd5, 2'b10);
    check("midscan drop", wr_drop, 1);
    check("midscan board", board, 18'h00015);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pos = 4'd0; #1;
    check("abort board_clr", board, 0);
    check("abort busy_clr", scan_busy, 0);
    check("abort state0", state, 2'b00);
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (scan_done) done_seen = 1;
    end
    check("abort no_done", done_seen, 0);
    check("abort win", win, 0);

    // Reset and write in the same cycle: the write is lost.
    rst = 1'b1; w_e = 1'b1; pos = 4'd4; player = 2'b01;
    tick();
    rst = 1'b0; w_e = 1'b0;
    check("rst_wr board", board, 0);
    check("rst_wr busy", scan_busy, 0);
    tick();
    check("rst_wr board2", board, 0);
    check("rst_wr drop", wr_drop, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_keeper.md
# board_keeper

Tic-tac-toe board store and result checker, directly downstream of `game_controller`. It stores the 3×3 board as nine 2-bit cells and commits the controller's `pos`/`player` on `w_e`. It returns the occupancy of the addressed cell as `state`, and raises `win`/`full` after a sequential 8-line scan following every committed move.

## Interface
Parameters:
- `SCAN_LINES`, default 8, number of winning lines scanned. Fixed at 8; no other value is supported.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset. Clears board and all state.
- `w_e` in 1: write-enable pulse from the game FSM.
- `pos` in 4: cell index 0–8, row-major (0 = top-left, 8 = bottom-right).
- `player` in 2: 2'b01 = player 1, 2'b10 = player 2.
- `state` out 2: content of cell `pos` (combinational read).
- `win` out 1: a completed line was found. Sticky until `rst`.
- `winner` out 2: player code owning the winning line. 2'b00 when `win`=0.
- `full` out 1: all nine cells are occupied, as of the last completed scan.
- `scan_busy` out 1: a scan is in progress.
- `scan_done` out 1: one-cycle pulse when a scan completes.
- `wr_drop` out 1: one-cycle pulse when a write request is rejected.
- `board` out 18: flattened board for display; cell i occupies bits [2i+1:2i].

## Operation
- Cell encoding: 00 empty, 01 player 1, 10 player 2. The value 11 is never stored.
- `state` read:
  - `pos` ≤ 8: returns that cell's contents.
  - `pos` ≥ 9: returns 2'b11, so the downstream busy check treats the position as occupied.
- A write is accepted on a rising edge when all of the following hold:
  - `w_e`=1
  - `pos` ≤ 8
  - the target cell is 00
  - `player` ∈ {01, 10}
  - FSM is IDLE
  - `win`=0
- When `w_e`=1 and any other condition fails, the board is unchanged and `wr_drop` pulses the next cycle.
- FSM states and transitions:
  - IDLE → SCAN on an accepted write. Line index `li` is set to 0 and the hit flag is cleared.
  - SCAN: checks one line per cycle, `li` = 0..7:
    - rows (0,1,2), (3,4,5), (6,7,8)
    - columns (0,3,6), (1,4,7), (2,5,8)
    - diagonals (0,4,8), (2,4,6)
  - A line matches when its three cells are equal and non-zero. Only the first matching line (lowest `li`) is latched.
  - SCAN → DONE after `li`=7. The scan always runs all 8 lines; there is no early exit.
  - DONE, one cycle:
    - `win` is set if a match was found, and `winner` is set to the matched code.
    - `full` is set to AND over all cells of (cell ≠ 00).
    - `scan_done` pulses.
    - Return to IDLE.
- Once `win`=1, all further writes are dropped until `rst`.
- A board can be both won and full; both flags are set together in that case.

## Timing
- Accepted write at edge N: cell updated and `board`/`state` reflect it after edge N.
- `scan_busy`=1 from edge N through edge N+8, covering SCAN cycles N+1…N+8.
- DONE occupies the cycle after edge N+8. `win`, `winner` and `full` are valid, and `scan_done`=1, after edge N+9.
- Write-to-result latency is 9 cycles. Minimum spacing between accepted writes is 10 cycles.
- `wr_drop` is registered, 1 cycle after the rejected request.
- Reset values: all cells 00, `board`=0, `win`=0, `winner`=00, `full`=0, `scan_busy`=0, `scan_done`=0, `wr_drop`=0, FSM IDLE.
- `state` follows `rst` combinationally via the cleared cells.
- `rst` mid-scan aborts the scan immediately. No `scan_done` pulse is produced.
- `rst` and `w_e` asserted in the same cycle: reset wins and the write is lost.

## Configuration
- `BOARD_WIN_LINE_EN` defined:
  - Adds output `win_line` [2:0], holding the index 0–7 of the latched winning line.
  - Valid while `win`=1; 0 otherwise and after reset.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Reset, then read every `pos` 0–8 → `state`=00. `pos`=12 → `state`=11. All flags 0.
- Write player 01 at pos 4 → `scan_busy` high for 8 cycles, `scan_done` at +9, `win`=0, `full`=0, `board`[9:8]=01.
- Write player 01 at 0, 4, 8, spaced 10 cycles apart → after the last scan, `win`=1 and `winner`=01. With the macro, `win_line`=6. A further write to pos 1 → `wr_drop` pulse, board unchanged.
- Fill with the non-winning pattern 01,10,01 / 01,10,10 / 10,01,01 → after the ninth scan, `full`=1, `win`=0.
- Write to an occupied cell, write with `pos`=9, write with `player`=11, and a write issued mid-scan → each produces `wr_drop` and leaves `board` unchanged.
- Assert `rst` at scan cycle 4 after a move that completes a row → no `scan_done`, `win`=0, `board`=0.
